cnf_scan_eval: RTL and testbench
================================

# cnf_scan_eval

Sequential, parametrised CNF evaluator. It holds a programmable clause bank of `NC` clauses over `NV` variables. It accepts variable assignments through a valid/ready handshake and scans the bank one clause per cycle. It returns SAT/UNSAT plus the index of the first falsified clause, and stops early on the first failure. It replaces fixed, generated per-formula combinational CNF netlists in the dependency-checking flow, so one instance serves any formula that fits in `NV`×`NC`.

## Interface
Parameters:
- `NV`, default 5: number of variables. Assignment bit k is variable v_(k+1).
- `NC`, default 8: clause-bank depth.
- `IW`, default `$clog2(NC)` (minimum 1): clause index width.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cl_we`, input, 1: clause write strobe. Honoured only when `cl_ready`=1.
- `cl_ready`, output, 1: high in IDLE only.
- `cl_addr`, input, IW: clause slot to write.
- `cl_en`, input, 1: enable bit for the slot. 0 means the slot is ignored (treated as satisfied).
- `cl_pos`, input, NV: positive-literal mask.
- `cl_neg`, input, NV: negative-literal mask.
- `in_valid`, input, 1: assignment valid.
- `in_ready`, output, 1: high in IDLE and `cl_we`=0.
- `in_assign`, input, NV: variable assignment.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: result consumed.
- `out_sat`, output, 1: 1 means every enabled clause is satisfied.
- `out_fail_idx`, output, IW: index of the first falsified clause. 0 when `out_sat`=1.
- `out_scanned`, output, IW+1: number of clauses evaluated for this result.

## Operation
- Clause satisfaction for slot i with assignment a: `|(pos_i & a) | |(neg_i & ~a)`.
- A disabled slot is satisfied.
- An enabled slot with `pos=neg=0` is falsified (empty clause).
- A slot with the same bit set in both `pos` and `neg` is a tautology. No special handling is required.
- State machine:
  - IDLE: accept a clause write, or accept an assignment. On handshake, latch `in_assign`, clear the index counter, go to SCAN.
  - SCAN: evaluate slot `idx`.
    - If the slot is falsified: latch `out_sat`=0, `out_fail_idx`=idx, `out_scanned`=idx+1; go to DONE.
    - Else if idx=NC-1: latch `out_sat`=1, `out_fail_idx`=0, `out_scanned`=NC; go to DONE.
    - Else idx+1.
  - DONE: `out_valid`=1 and the outputs are held stable. On `out_ready`, go to IDLE.
- Clause writes and assignment acceptance are mutually exclusive. With `cl_we` high in IDLE, the write wins and `in_ready` is 0 that cycle.
- `cl_we` outside IDLE is dropped. `cl_ready`=0 signals this to the producer.
- `in_assign` may change freely after acceptance. Only the latched copy is used.

## Timing
- Reset values:
  - State IDLE, `cl_ready`=1, `in_ready`=1.
  - `out_valid`=0, `out_sat`=0, `out_fail_idx`=0, `out_scanned`=0.
  - All clause enable bits are 0. Masks need not be cleared.
- Latency: let the handshake occur on edge E0.
  - Slot k is evaluated in the cycle after edge Ek.
  - `out_valid` rises after edge E(f+1) for the first failure at slot f.
  - `out_valid` rises after edge E(NC) when the result is SAT.
  - Minimum latency is 2 cycles; maximum is NC+1.
- A clause write on edge E takes effect for any scan accepted at E+1 or later.
- Throughput: one assignment per (scan cycles + 1 DONE cycle + 1 IDLE cycle) when `out_ready` is held high.
- If `out_ready` is already high when `out_valid` rises, DONE lasts exactly one cycle.
- Reset mid-scan or in DONE aborts the operation: no result is produced and the bank is disabled. `rst` overrides every other input.
- Boundary case NC=1: the index counter never increments, and a scan takes one cycle.

## Structure
- Package `cnf_pkg` holds:
  - State enum `cnf_state_t` (IDLE, SCAN, DONE).
  - Function `clause_sat(pos, neg, en, a)`, parametrised on width via a `NV`-sized `localparam` in the user.
- Sub-module `cnf_clause_bank` holds the clause storage:
  - Write port.
  - Combinational read port by `idx`.
  - Reset of the enable bits.
- The top level holds the FSM, the assignment latch, the index counter, and the result registers.

## Test plan
Common setup: NV=5, NC=8. Slots 0–3 are loaded as follows; slots 4–7 stay disabled.

| Slot | pos | neg | Clause |
|---|---|---|---|
| 0 | 00101 | 10000 | v1∨v3∨¬v5 |
| 1 | 00000 | 01100 | ¬v3∨¬v4 |
| 2 | 11010 | 00001 | v2∨v4∨v5∨¬v1 |
| 3 | 00011 | 00100 | v1∨v2∨¬v3 |

1. Assign 00000 → `out_sat`=1, `out_fail_idx`=0, `out_scanned`=8, `out_valid` 9 cycles after acceptance.
2. Assign 01100 → `out_sat`=0, `out_fail_idx`=1, `out_scanned`=2, latency 3.
3. Assign 10000 → `out_sat`=0, `out_fail_idx`=0, `out_scanned`=1, latency 2.
4. Hold `out_ready`=0 for 5 cycles in DONE while driving `cl_we` and `in_valid` → outputs stable, `cl_ready`=`in_ready`=0, and the bank is unchanged (rerun case 2 and get the same result).
5. Enable slot 7 with pos=neg=0, assign 00000 → `out_sat`=0, `out_fail_idx`=7, `out_scanned`=8.
6. Assert `rst` at scan cycle 3 of case 1 → next cycle IDLE, `out_valid`=0. A new assignment with no reload returns `out_sat`=1 (all slots disabled).

Source files
------------

// File: rtl/cnf_pkg.sv
// Shared types and helpers for the sequential CNF evaluator.
package cnf_pkg;

  // Widest variable count the clause helper accepts; callers zero-extend.
  localparam int CNF_MAX_NV = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cnf_state_t;

  // Clause truth value. Zero-extended upper bits have pos=neg=0, so they
  // never contribute a literal. A disabled slot always reads as satisfied.
  function automatic logic clause_sat(input logic [CNF_MAX_NV-1:0] pos,
                                      input logic [CNF_MAX_NV-1:0] neg,
                                      input logic                  en,
                                      input logic [CNF_MAX_NV-1:0] a);
    return !en || (|(pos & a)) || (|(neg & ~a));
  endfunction

endpackage

// File: rtl/cnf_clause_bank.sv
// Clause storage: one write port, one combinational read port.
// Only the enable bits are reset; masks are don't-care while disabled.
module cnf_clause_bank #(
  parameter int NV = 5,
  parameter int NC = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic          wen,
  input  logic [NV-1:0] wpos,
  input  logic [NV-1:0] wneg,
  input  logic [IW-1:0] raddr,
  output logic          ren,
  output logic [NV-1:0] rpos,
  output logic [NV-1:0] rneg
);

  logic [NC-1:0] en_q;
  logic [NV-1:0] pos_q [NC];
  logic [NV-1:0] neg_q [NC];

  // Enable bits: cleared by reset, otherwise written with the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
    end else if (we && (int'(waddr) < NC)) begin
      en_q[waddr] <= wen;
    end
  end

  // Literal masks: plain storage, no reset.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < NC)) begin
      pos_q[waddr] <= wpos;
      neg_q[waddr] <= wneg;
    end
  end

  assign ren  = en_q[raddr];
  assign rpos = pos_q[raddr];
  assign rneg = neg_q[raddr];

endmodule

// File: rtl/cnf_scan_eval.sv
// Sequential CNF evaluator: scans the clause bank one slot per cycle
// against a latched assignment and stops at the first falsified clause.
module cnf_scan_eval
  import cnf_pkg::*;
#(
  parameter int NV = 5,
  parameter int NC = 8,
  parameter int IW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cl_we,
  output logic          cl_ready,
  input  logic [IW-1:0] cl_addr,
  input  logic          cl_en,
  input  logic [NV-1:0] cl_pos,
  input  logic [NV-1:0] cl_neg,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NV-1:0] in_assign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sat,
  output logic [IW-1:0] out_fail_idx,
  output logic [IW:0]   out_scanned
);

  localparam int PAD = CNF_MAX_NV - NV;

  cnf_state_t    state_q;
  logic [IW-1:0] idx_q;
  logic [NV-1:0] assign_q;
  logic          valid_q;
  logic          sat_q;
  logic [IW-1:0] fail_q;
  logic [IW:0]   scanned_q;

  logic          slot_en;
  logic [NV-1:0] slot_pos;
  logic [NV-1:0] slot_neg;
  logic          slot_ok;
  logic          take_in;

  // A write in IDLE blocks assignment acceptance for that cycle.
  assign cl_ready = (state_q == IDLE);
  assign in_ready = (state_q == IDLE) && !cl_we;
  assign take_in  = in_ready && in_valid;

  cnf_clause_bank #(.NV(NV), .NC(NC), .IW(IW)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (cl_we && (state_q == IDLE)),
    .waddr (cl_addr),
    .wen   (cl_en),
    .wpos  (cl_pos),
    .wneg  (cl_neg),
    .raddr (idx_q),
    .ren   (slot_en),
    .rpos  (slot_pos),
    .rneg  (slot_neg)
  );

  assign slot_ok = clause_sat({{PAD{1'b0}}, slot_pos}, {{PAD{1'b0}}, slot_neg},
                              slot_en, {{PAD{1'b0}}, assign_q});

  // Assignment latch: captured on the input handshake only.
  always_ff @(posedge clk) begin
    if (take_in) begin
      assign_q <= in_assign;
    end
  end

  // Control FSM with scan index and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      fail_q    <= '0;
      scanned_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_in) begin
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (!slot_ok) begin
            sat_q     <= 1'b0;
            fail_q    <= idx_q;
            scanned_q <= {1'b0, idx_q} + 1'b1;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else if (idx_q == IW'(NC - 1)) begin
            sat_q     <= 1'b1;
            fail_q    <= '0;
            scanned_q <= (IW + 1)'(NC);
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = valid_q;
  assign out_sat      = sat_q;
  assign out_fail_idx = fail_q;
  assign out_scanned  = scanned_q;

endmodule

// File: tb/tb_cnf_scan_eval.sv
// Self-checking bench for cnf_scan_eval (NV=5, NC=8) with a result scoreboard.
module tb_cnf_scan_eval;

  localparam int NV = 5;
  localparam int NC = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cl_we;
  logic          cl_ready;
  logic [IW-1:0] cl_addr;
  logic          cl_en;
  logic [NV-1:0] cl_pos;
  logic [NV-1:0] cl_neg;
  logic          in_valid;
  logic          in_ready;
  logic [NV-1:0] in_assign;
  logic          out_valid;
  logic          out_ready;
  logic          out_sat;
  logic [IW-1:0] out_fail_idx;
  logic [IW:0]   out_scanned;

  typedef struct {
    logic          sat;
    logic [IW-1:0] idx;
    logic [IW:0]   scanned;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic          m_en  [NC];
  logic [NV-1:0] m_pos [NC];
  logic [NV-1:0] m_neg [NC];

  cnf_scan_eval #(.NV(NV), .NC(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .cl_we        (cl_we),
    .cl_ready     (cl_ready),
    .cl_addr      (cl_addr),
    .cl_en        (cl_en),
    .cl_pos       (cl_pos),
    .cl_neg       (cl_neg),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_assign    (in_assign),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sat      (out_sat),
    .out_fail_idx (out_fail_idx),
    .out_scanned  (out_scanned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference evaluation of the bench's own copy of the bank.
  function automatic exp_t model(input logic [NV-1:0] a);
    exp_t e;
    e.sat = 1'b1; e.idx = '0; e.scanned = 4'(NC); e.lat = NC + 1;
    for (int i = 0; i < NC; i++) begin
      logic ok;
      ok = !m_en[i];
      for (int b = 0; b < NV; b++) begin
        if (m_pos[i][b] && a[b]) ok = 1'b1;
        if (m_neg[i][b] && !a[b]) ok = 1'b1;
      end
      if (!ok) begin
        e.sat = 1'b0; e.idx = IW'(i); e.scanned = 4'(i + 1); e.lat = i + 2;
        return e;
      end
    end
    return e;
  endfunction

  task automatic push_exp(input logic sat, input int idx, input int scanned, input int lat);
    exp_t e;
    e.sat = sat; e.idx = IW'(idx); e.scanned = 4'(scanned); e.lat = lat;
    sb.push_back(e);
  endtask

  // Clause write with a competing assignment offered in the same cycle.
  task automatic wr(input int addr, input logic en, input logic [NV-1:0] pos, input logic [NV-1:0] neg);
    cl_we = 1'b1; cl_addr = IW'(addr); cl_en = en; cl_pos = pos; cl_neg = neg;
    in_valid = 1'b1; in_assign = 5'b00000;
    #1 chk("in_ready_during_write", in_ready, 0);
    @(posedge clk); #1;
    cl_we = 1'b0; in_valid = 1'b0;
    chk("write_not_accept_assign", cl_ready, 1);
    chk("write_no_result", out_valid, 0);
    m_en[addr] = en; m_pos[addr] = pos; m_neg[addr] = neg;
  endtask

  task automatic run_scan(input logic [NV-1:0] a, input int hold);
    exp_t e;
    int   lat;
    logic got;
    out_ready = (hold == 0);
    in_valid = 1'b1; in_assign = a;
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_assign = ~a;
    lat = 1; got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
    e = sb.pop_front();
    chk("timeout", got, 1);
    chk("sat", out_sat, e.sat);
    chk("fail_idx", out_fail_idx, e.idx);
    chk("scanned", out_scanned, e.scanned);
    chk("latency", lat, e.lat);
    if (hold > 0) begin
      cl_we = 1'b1; cl_addr = 3'd1; cl_en = 1'b0; cl_pos = '0; cl_neg = '0;
      in_valid = 1'b1; in_assign = 5'b10101;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_sat", out_sat, e.sat);
        chk("hold_idx", out_fail_idx, e.idx);
        chk("hold_scanned", out_scanned, e.scanned);
        chk("hold_cl_ready", cl_ready, 0);
        chk("hold_in_ready", in_ready, 0);
      end
      cl_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_one_cycle", out_valid, 0);
    chk("back_to_idle", cl_ready, 1);
  endtask

  initial begin
    rst = 1'b1; cl_we = 1'b0; cl_addr = '0; cl_en = 1'b0; cl_pos = '0; cl_neg = '0;
    in_valid = 1'b0; in_assign = '0; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin m_en[i] = 1'b0; m_pos[i] = '0; m_neg[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cl_ready", cl_ready, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_fail_idx", out_fail_idx, 0);
    chk("rst_scanned", out_scanned, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    wr(0, 1'b1, 5'b00101, 5'b10000);
    wr(1, 1'b1, 5'b00000, 5'b01100);
    wr(2, 1'b1, 5'b11010, 5'b00001);
    wr(3, 1'b1, 5'b00011, 5'b00100);

    // Cases 1-3: SAT, fail at slot 1, fail at slot 0.
    push_exp(1'b1, 0, 8, 9); run_scan(5'b00000, 0);
    push_exp(1'b0, 1, 2, 3); run_scan(5'b01100, 0);
    push_exp(1'b0, 0, 1, 2); run_scan(5'b10000, 0);

    // Case 4: stall in DONE with writes and assignments offered, then rerun.
    push_exp(1'b0, 1, 2, 3); run_scan(5'b01100, 5);
    push_exp(1'b0, 1, 2, 3); run_scan(5'b01100, 0);

    // Case 5: enabled empty clause in the last slot.
    wr(7, 1'b1, 5'b00000, 5'b00000);
    push_exp(1'b0, 7, 8, 9); run_scan(5'b00000, 0);

    // Case 6: reset during the scan aborts and disables the bank.
    wr(7, 1'b0, 5'b00000, 5'b00000);
    out_ready = 1'b1; in_valid = 1'b1; in_assign = 5'b00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_idle", cl_ready, 1);
    chk("abort_in_ready", in_ready, 1);
    for (int i = 0; i < NC; i++) m_en[i] = 1'b0;
    repeat (NC + 2) begin
      @(posedge clk); #1;
      chk("abort_no_result", out_valid, 0);
    end
    push_exp(1'b1, 0, 8, 9); run_scan(5'b01100, 0);

    // Random bank contents against the reference model.
    for (int i = 0; i < NC; i++)
      wr(i, 1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom & $urandom));
    for (int t = 0; t < 12; t++) begin
      logic [NV-1:0] a;
      a = 5'($urandom);
      sb.push_back(model(a));
      run_scan(a, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
